// File: rtl/execute_unit.sv
// Execute stage: register file, ALU with NZCV flags, conditional branch with flush
// window, and an optional shift-add multiplier built only when EXEC_MUL_EN is defined.
module execute_unit #(
   parameter int DATA_W       = 32,
   parameter int NREGS        = 16,
   parameter int FLUSH_CYCLES = 2,
   localparam int SEL_W       = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        uop,
   input  logic              num_to_rhs,
   input  logic [DATA_W-1:0] num,
   input  logic [SEL_W-1:0]  sel_p0,
   input  logic [SEL_W-1:0]  sel_p1,
   input  logic [SEL_W-1:0]  sel_in,
   input  logic [3:0]        branch_cond,
   output logic              global_disable,
   output logic [DATA_W-1:0] delta_instruction,
   output logic              branch_taken,
   output logic [3:0]        flags,
   output logic              busy,
   input  logic [SEL_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   localparam logic [4:0] OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3, OP_ORR = 5'd4,
                          OP_CMP = 5'd5, OP_EOR = 5'd6, OP_MVN = 5'd7, OP_MOV = 5'd8,
                          OP_MUL = 5'd9, OP_B   = 5'd10;
   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [3:0]        flags_q, flags_d;
   logic [FC_W-1:0]   flush_q, flush_d;
   logic              br_q, br_d;
   logic [DATA_W-1:0] delta_q, delta_d;

   logic [DATA_W-1:0] lhs, rhs;
   logic [DATA_W:0]   add_w, sub_w;
   logic              exec, nz_upd, wr_en;
   logic [SEL_W-1:0]  wr_sel;
   logic [DATA_W-1:0] wr_data;

`ifdef EXEC_MUL_EN
   typedef enum logic [0:0] {S_IDLE, S_MUL} mul_state_e;
   localparam int CNT_W = $clog2(DATA_W);

   mul_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, mul_res;
   logic [SEL_W-1:0]  mdst_q;
   logic              mul_start, mul_done;

   assign mul_res  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_done = (state_q == S_MUL) && (cnt_q == CNT_W'(DATA_W - 1));
   assign busy     = (state_q == S_MUL);
   assign in_ready = rst_n && (state_q == S_IDLE);
`else
   assign busy     = 1'b0;
   assign in_ready = rst_n;
`endif

   function automatic logic add_ovf(input logic signed [DATA_W-1:0] a, b, s);
      return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a, b, s);
      return (a[DATA_W-1] != b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
   endfunction

   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      lhs     = regs_q[sel_p0];
      rhs     = num_to_rhs ? num : regs_q[sel_p1];
      add_w   = {1'b0, lhs} + {1'b0, rhs};
      sub_w   = {1'b0, lhs} - {1'b0, rhs};
      // Anything accepted inside the flush window is dropped without side effects.
      exec    = in_valid && in_ready && (flush_q == '0);
      flags_d = flags_q;
      nz_upd  = 1'b0;
      wr_en   = 1'b0;
      wr_sel  = sel_in;
      wr_data = '0;
      br_d    = 1'b0;
      delta_d = delta_q;
      flush_d = (flush_q != '0) ? flush_q - FC_W'(1) : flush_q;
`ifdef EXEC_MUL_EN
      mul_start = 1'b0;
`endif
      if (exec) begin
         case (uop)
            OP_ADD: begin
               wr_en   = 1'b1;
               wr_data = add_w[DATA_W-1:0];
               flags_d = {add_w[DATA_W-1], add_w[DATA_W-1:0] == '0, add_w[DATA_W],
                          add_ovf(lhs, rhs, add_w[DATA_W-1:0])};
            end
            OP_SUB, OP_CMP: begin
               wr_en   = (uop == OP_SUB);
               wr_data = sub_w[DATA_W-1:0];
               flags_d = {sub_w[DATA_W-1], sub_w[DATA_W-1:0] == '0, !sub_w[DATA_W],
                          sub_ovf(lhs, rhs, sub_w[DATA_W-1:0])};
            end
            OP_AND: begin wr_en = 1'b1; nz_upd = 1'b1; wr_data = lhs & rhs; end
            OP_ORR: begin wr_en = 1'b1; nz_upd = 1'b1; wr_data = lhs | rhs; end
            OP_EOR: begin wr_en = 1'b1; nz_upd = 1'b1; wr_data = lhs ^ rhs; end
            OP_MVN: begin wr_en = 1'b1; nz_upd = 1'b1; wr_data = ~rhs; end
            OP_MOV: begin wr_en = 1'b1; nz_upd = 1'b1; wr_data = num_to_rhs ? num : lhs; end
`ifdef EXEC_MUL_EN
            OP_MUL: mul_start = 1'b1;
`endif
            OP_B: begin
               if (cond_pass(branch_cond, flags_q)) begin
                  br_d    = 1'b1;
                  delta_d = num;
                  flush_d = FC_W'(FLUSH_CYCLES);
               end
            end
            default: ;
         endcase
      end
`ifdef EXEC_MUL_EN
      // Product retires on the final busy cycle; issue is stalled so no port conflict.
      if (mul_done) begin
         wr_en   = 1'b1;
         nz_upd  = 1'b1;
         wr_sel  = mdst_q;
         wr_data = mul_res;
      end
`endif
      if (nz_upd) flags_d[3:2] = {wr_data[DATA_W-1], wr_data == '0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         flags_q <= '0;
         flush_q <= '0;
         br_q    <= 1'b0;
         delta_q <= '0;
      end else begin
         if (wr_en) regs_q[wr_sel] <= wr_data;
         flags_q <= flags_d;
         flush_q <= flush_d;
         br_q    <= br_d;
         delta_q <= delta_d;
      end
   end

`ifdef EXEC_MUL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (mul_start) begin
               state_q <= S_MUL;
               cnt_q   <= '0;
            end
            S_MUL: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (mul_done) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Shift-add datapath: one multiplier bit consumed per cycle, LSB first.
   always_ff @(posedge clk) begin
      if (mul_start) begin
         mcand_q  <= lhs;
         mplier_q <= rhs;
         acc_q    <= '0;
         mdst_q   <= sel_in;
      end else if (state_q == S_MUL) begin
         acc_q    <= mul_res;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end
`endif

   assign flags             = flags_q;
   assign global_disable    = (flush_q != '0);
   assign branch_taken      = br_q;
   assign delta_instruction = delta_q;
   assign dbg_data          = regs_q[dbg_sel];

endmodule

// File: tb/tb_execute_unit.sv
// Randomised bench for execute_unit against a behavioural model of registers, NZCV
// flags and the branch flush window; MUL checks follow the EXEC_MUL_EN build option.
module tb_execute_unit;
   localparam int DATA_W = 32;
   localparam int NREGS = 16;
   localparam int FLUSH_CYCLES = 2;
   localparam logic [4:0] U_NOP = 5'd0, U_ADD = 5'd1, U_SUB = 5'd2, U_AND = 5'd3,
                          U_ORR = 5'd4, U_CMP = 5'd5, U_EOR = 5'd6, U_MVN = 5'd7,
                          U_MOV = 5'd8, U_MUL = 5'd9, U_B = 5'd10;

   logic        clk, rst_n, in_valid, in_ready, num_to_rhs;
   logic [4:0]  uop;
   logic [31:0] num, delta_instruction, dbg_data;
   logic [3:0]  sel_p0, sel_p1, sel_in, dbg_sel, branch_cond, flags;
   logic        global_disable, branch_taken, busy;

   execute_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .uop(uop),
      .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1),
      .sel_in(sel_in), .branch_cond(branch_cond), .global_disable(global_disable),
      .delta_instruction(delta_instruction), .branch_taken(branch_taken),
      .flags(flags), .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mregs [NREGS];
   logic [3:0]  mflags;
   logic [31:0] mdelta;
   int          mflush;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) mregs[i] = '0;
      mflags = '0;
      mdelta = '0;
      mflush = 0;
   endtask

   // ARM condition: even codes test a base predicate, odd codes its inverse, 0xF never.
   function automatic bit cond_ok(input logic [3:0] cc);
      bit n, z, c, v, base;
      {n, z, c, v} = mflags;
      case (cc[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return (cc == 4'hF) ? 1'b0 : (base ^ cc[0]);
   endfunction

   task automatic model_apply(input logic [4:0] op, input logic imm, input logic [31:0] n,
                              input int p0, input int p1, input int dst,
                              input logic [3:0] cc, output bit taken, output bit mul_go);
      logic [31:0] a, b, r;
      longint u, s;
      bit discard;
      a = mregs[p0];
      b = imm ? n : mregs[p1];
      taken = 1'b0;
      mul_go = 1'b0;
      discard = (mflush > 0);
      if (mflush > 0) mflush--;
      if (discard) return;
      case (op)
         U_ADD: begin
            r = a + b;
            u = longint'(a) + longint'(b);
            s = longint'($signed(a)) + longint'($signed(b));
            mflags = {r[31], r == 0, u != longint'(r), s != longint'($signed(r))};
            mregs[dst] = r;
         end
         U_SUB, U_CMP: begin
            r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            mflags = {r[31], r == 0, a >= b, s != longint'($signed(r))};
            if (op == U_SUB) mregs[dst] = r;
         end
         U_AND, U_ORR, U_EOR, U_MVN, U_MOV: begin
            case (op)
               U_AND:   r = a & b;
               U_ORR:   r = a | b;
               U_EOR:   r = a ^ b;
               U_MVN:   r = ~b;
               default: r = imm ? n : a;
            endcase
            mflags[3:2] = {r[31], r == 0};
            mregs[dst] = r;
         end
`ifdef EXEC_MUL_EN
         U_MUL: begin
            r = a * b;
            mflags[3:2] = {r[31], r == 0};
            mregs[dst] = r;
            mul_go = 1'b1;
         end
`endif
         U_B: begin
            if (cond_ok(cc)) begin
               taken = 1'b1;
               mdelta = n;
               mflush = FLUSH_CYCLES;
            end
         end
         default: ;
      endcase
   endtask

   task automatic issue(input logic [4:0] op, input logic imm, input logic [31:0] n,
                        input int p0, input int p1, input int dst, input logic [3:0] cc);
      bit taken, mul_go;
      int waits, cyc;
      @(negedge clk);
      uop = op; num_to_rhs = imm; num = n; branch_cond = cc;
      sel_p0 = 4'(p0); sel_p1 = 4'(p1); sel_in = 4'(dst); dbg_sel = 4'(dst);
      in_valid = 1'b1;
      waits = 0;
      while (!in_ready && waits < 100) begin
         @(negedge clk);
         waits++;
         if (mflush > 0) mflush--;
      end
      chk("issue_ready", in_ready, 1);
      chk("gdis_pre", global_disable, mflush > 0);
      model_apply(op, imm, n, p0, p1, dst, cc, taken, mul_go);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
`ifdef EXEC_MUL_EN
      if (mul_go) begin
         chk("mul_busy", busy, 1);
         chk("mul_ready_low", in_ready, 0);
         cyc = 0;
         while (busy && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         chk("mul_cycles", cyc, DATA_W);
      end
`endif
      chk("br_taken", branch_taken, taken);
      chk("gdis", global_disable, mflush > 0);
      chk("delta", delta_instruction, mdelta);
      chk("flags", flags, mflags);
      chk("reg", dbg_data, mregs[dst]);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit taken, mul_go;
      int cyc;
      logic [4:0] op;
      logic [31:0] n;
      rst_n = 1'b0; in_valid = 1'b0; uop = '0; num_to_rhs = 1'b0; num = '0;
      sel_p0 = '0; sel_p1 = '0; sel_in = '0; branch_cond = '0; dbg_sel = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gdis", global_disable, 0);
      chk("rst_br", branch_taken, 0);
      chk("rst_delta", delta_instruction, 0);
      chk("rst_flags", flags, 0);
      chk("rst_r0", dbg_data, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // Add with zero flags
      issue(U_MOV, 1, 32'hCAFE, 0, 0, 1, 0);
      issue(U_MOV, 1, 32'hDEAD, 0, 0, 2, 0);
      issue(U_ADD, 0, 0, 1, 2, 4, 0);
      chk("tp_add_r4", dbg_data, 32'h0001A9AB);
      chk("tp_add_flags", flags, 4'b0000);

      // Taken branch and flush window
      issue(U_MOV, 1, 1, 0, 0, 6, 0);
      issue(U_MOV, 1, 1, 0, 0, 7, 0);
      issue(U_CMP, 0, 0, 6, 7, 0, 0);
      chk("tp_cmp_flags", flags, 4'b0110);
      issue(U_B, 1, 32'h10, 0, 0, 0, 4'h0);
      chk("tp_b_taken", branch_taken, 1);
      chk("tp_b_delta", delta_instruction, 32'h10);
      chk("tp_b_gdis1", global_disable, 1);
      issue(U_MOV, 1, 5, 0, 0, 8, 0);
      chk("tp_b_pulse", branch_taken, 0);
      chk("tp_b_gdis2", global_disable, 1);
      chk("tp_flush_r8", dbg_data, 0);
      issue(U_NOP, 0, 0, 0, 0, 8, 0);
      chk("tp_b_gdis3", global_disable, 0);
      issue(U_B, 1, 32'h20, 0, 0, 0, 4'h1);
      chk("tp_ne_taken", branch_taken, 0);
      chk("tp_ne_gdis", global_disable, 0);
      chk("tp_ne_delta", delta_instruction, 32'h10);

      // Carry, zero and signed overflow boundaries
      issue(U_MOV, 1, 32'hFFFFFFFF, 0, 0, 1, 0);
      issue(U_ADD, 1, 1, 1, 0, 2, 0);
      chk("tp_wrap_r2", dbg_data, 0);
      chk("tp_wrap_flags", flags, 4'b0110);
      issue(U_MOV, 1, 32'h7FFFFFFF, 0, 0, 3, 0);
      issue(U_ADD, 1, 1, 3, 0, 9, 0);
      chk("tp_ovf_flags", flags, 4'b1001);

      // Multiplier
      issue(U_MOV, 1, 32'h1234, 0, 0, 1, 0);
      issue(U_MOV, 1, 32'h10, 0, 0, 2, 0);
`ifdef EXEC_MUL_EN
      @(negedge clk);
      uop = U_MUL; num_to_rhs = 0; sel_p0 = 1; sel_p1 = 2; sel_in = 3; dbg_sel = 3;
      in_valid = 1'b1;
      model_apply(U_MUL, 0, 0, 1, 2, 3, 0, taken, mul_go);
      @(posedge clk);
      #1;
      uop = U_ADD; num_to_rhs = 1; num = 1; sel_p0 = 3; sel_in = 5;
      chk("mul_busy_start", busy, 1);
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("mul_stall", cyc, 32);
      chk("mul_r3", dbg_data, 32'h00012340);
      model_apply(U_ADD, 1, 1, 3, 0, 5, 0, taken, mul_go);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dbg_sel = 5;
      #1;
      chk("held_add_r5", dbg_data, 32'h00012341);
      chk("held_add_flags", flags, mflags);
`else
      issue(U_MUL, 0, 0, 1, 2, 3, 0);
      chk("mul_nop_r3", dbg_data, 32'h7FFFFFFF);
`endif

      // Random traffic against the model
      for (int k = 0; k < 120; k++) begin
         op = 5'($urandom_range(0, 12));
         case ($urandom_range(0, 4))
            0: n = 32'h0;
            1: n = 32'hFFFFFFFF;
            2: n = 32'h7FFFFFFF;
            3: n = 32'h80000000;
            default: n = $urandom;
         endcase
         issue(op, 1'($urandom_range(0, 1)), n, $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), 4'($urandom_range(0, 15)));
      end

      // Asynchronous reset, mid-multiply when the multiplier is built
`ifdef EXEC_MUL_EN
      @(negedge clk);
      uop = U_MUL; num_to_rhs = 1; num = 32'h3; sel_p0 = 1; sel_in = 3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mul_busy_mid", busy, 1);
`endif
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_gdis", global_disable, 0);
      chk("arst_br", branch_taken, 0);
      chk("arst_delta", delta_instruction, 0);
      chk("arst_flags", flags, 0);
      for (int i = 0; i < NREGS; i++) begin
         dbg_sel = 4'(i);
         #1;
         chk($sformatf("arst_r%0d", i), dbg_data, 0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      issue(U_MOV, 1, 32'h55, 0, 0, 3, 0);
      chk("post_rst_r3", dbg_data, 32'h55);
      issue(U_SUB, 1, 32'h56, 3, 0, 4, 0);
      chk("post_rst_sub", dbg_data, 32'hFFFFFFFF);
      chk("post_rst_flags", flags, 4'b1000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Parametrised successor to the single-cycle Execute stage.
- Register file of NREGS x DATA_W with an ALU and NZCV flags.
- Conditional branch evaluation with flush control, an iterative multi-cycle multiplier, and valid/ready issue handshake.
- Sits between decode and fetch. Decode issues micro-ops; fetch consumes delta_instruction and global_disable.

Parameters:
DATA_W, 32, datapath and register width
NREGS, 16, register count (power of 2); SEL_W = clog2(NREGS)
FLUSH_CYCLES, 2, cycles global_disable stays high after a taken branch (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  micro-op present
in_ready  out  1  unit can accept micro-op
uop  in  5  0 NOP,1 ADD,2 SUB,3 AND,4 ORR,5 CMP,6 EOR,7 MVN,8 MOV,9 MUL,10 B; others = NOP
num_to_rhs  in  1  rhs = num instead of reg[sel_p1] (MOV: source = num instead of reg[sel_p0])
num  in  DATA_W  immediate / branch offset
sel_p0  in  SEL_W  lhs register
sel_p1  in  SEL_W  rhs register
sel_in  in  SEL_W  destination register
branch_cond  in  4  ARM condition code for B
global_disable  out  1  flush request to upstream
delta_instruction  out  DATA_W  branch offset, valid while branch_taken
branch_taken  out  1  one-cycle pulse
flags  out  4  {N,Z,C,V}
busy  out  1  multiplier running
dbg_sel  in  SEL_W  debug read address
dbg_data  out  DATA_W  reg[dbg_sel], combinational

Behaviour:
- Reset (async, rst_n=0): all registers 0, flags 0, global_disable 0, branch_taken 0, delta_instruction 0, busy 0, FSM IDLE, flush counter 0. in_ready is 0 during reset and 1 after release.
- Accept: in_valid & in_ready at rising edge. Operand reads are combinational from the register file.
- Single-cycle ops write reg[sel_in] at the accepting edge. A dependent op issued the next cycle sees the new value.
- ADD/SUB: result modulo 2^DATA_W. Update N, Z, C (ADD carry-out; SUB/CMP C = no borrow, ARM style) and V (signed overflow).
- CMP: computes lhs-rhs, updates NZCV, no writeback.
- AND/ORR/EOR/MVN(~rhs)/MOV/MUL: update N and Z only; C and V unchanged.
- B: evaluate branch_cond against flags (ARM 0x0 EQ ... 0xE AL; 0xF never). If true:
  - next cycle: branch_taken=1 for one cycle, delta_instruction=num (held until the next taken branch);
  - global_disable=1 for exactly FLUSH_CYCLES cycles starting the same cycle.
  - If false: no outputs change.
- While global_disable=1: in_ready stays 1, accepted ops are discarded (no writeback, no flag change, no branch). A B accepted while global_disable=1 is also discarded.
- MUL FSM IDLE -> MUL -> IDLE. On accept: latch operands and sel_in; busy=1, in_ready=0 for DATA_W cycles. Shift-add one bit per cycle. Low DATA_W bits of the product are written on the last busy cycle. busy and in_ready return to their idle values the cycle after the write.
- A MUL accepted while flushing is discarded and does not start the FSM.
- Register 0 is ordinary (writable).
- NOP and unknown uops: no state change.
- Reset mid-MUL: aborts the FSM, no writeback, registers cleared.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: multiplier FSM and busy as specified.
- Undefined: uop 9 behaves as NOP, busy tied 0, in_ready is 1 whenever out of reset, and no multiplier logic is synthesised.

Test Plan:
- MOV #0xCAFE->r1, MOV #0xDEAD->r2, ADD r1,r2->r4 -> dbg r4=0x0001A9AB; flags N=0,Z=0,C=0,V=0.
- MOV #1->r6, MOV #1->r7, CMP r6,r7, then B cond=0 (EQ) num=0x10 -> flags Z=1,C=1; next cycle branch_taken pulse, delta_instruction=0x10, global_disable high 2 cycles. A MOV #5->r8 issued in the flush window leaves r8=0.
- After CMP r6,r7, B cond=1 (NE) -> branch_taken and global_disable stay 0.
- MOV #0xFFFFFFFF->r1, ADD r1 + #1->r2 -> r2=0, Z=1, C=1, V=0. MOV #0x7FFFFFFF->r3, ADD r3 + #1 -> N=1, V=1.
- EXEC_MUL_EN: MOV #0x1234->r1, MOV #0x10->r2, MUL r1,r2->r3 -> in_ready low 32 cycles, busy high, then r3=0x00012340. An op held valid during busy is accepted only afterwards.
- Assert rst_n=0 at cycle 10 of a MUL -> busy=0 immediately, r3=0 and all regs 0. After release, the first op is accepted normally.
